// File: rtl/fir_interp2.sv
// Purpose: 3-tap polyphase FIR interpolate-by-2 (even = H0*x[k] + H2*x[k-1], odd = H1*x[k]); optional flush via FIR_INTERP_FLUSH_EN.
// Latency: even sample valid the cycle after the input is accepted, odd sample follows; one input per 2 cycles.
// Backpressure: outputs held while out_ready=0; in_ready only in IDLE, or in ODD when the odd sample drains this cycle.
module fir_interp2 #(
    parameter int WIDTH  = 8,
    parameter int COEF_W = 8,
    parameter int H0     = 1,
    parameter int H1     = 2,
    parameter int H2     = 1,
    parameter int OUT_W  = WIDTH + COEF_W + 1
) (
    input  logic               clk,
    input  logic               rst,
`ifdef FIR_INTERP_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   y_out,
    output logic               out_odd
);

    typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

    // Coefficients trimmed to COEF_W, then sign-extended to the output width
    localparam logic signed [COEF_W-1:0] H0_C = COEF_W'(H0);
    localparam logic signed [COEF_W-1:0] H1_C = COEF_W'(H1);
    localparam logic signed [COEF_W-1:0] H2_C = COEF_W'(H2);
    localparam logic signed [OUT_W-1:0]  H0_W = OUT_W'(H0_C);
    localparam logic signed [OUT_W-1:0]  H1_W = OUT_W'(H1_C);
    localparam logic signed [OUT_W-1:0]  H2_W = OUT_W'(H2_C);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   x_cur_q, x_cur_d;
    logic [WIDTH-1:0]   x_prev_q, x_prev_d;
    logic [OUT_W-1:0]   y_q, y_d;

    logic               flush_req;
    logic               in_xfer;
    logic               out_xfer;
    logic signed [OUT_W-1:0] x_in_w;
    logic signed [OUT_W-1:0] x_cur_w;
    logic signed [OUT_W-1:0] even_sum;
    logic signed [OUT_W-1:0] odd_prod;

`ifdef FIR_INTERP_FLUSH_EN
    // Flush only takes effect while idle; it blocks input for that cycle
    assign flush_req = flush && (state_q == IDLE);
`else
    assign flush_req = 1'b0;
`endif

    // Full-precision products: every operand is sign-extended to OUT_W first
    assign x_in_w   = OUT_W'($signed(x_in));
    assign x_cur_w  = OUT_W'($signed(x_cur_q));
    assign even_sum = (x_in_w * H0_W) + (x_cur_w * H2_W);
    assign odd_prod = x_cur_w * H1_W;

    assign in_ready  = ((state_q == IDLE) && !flush_req) || ((state_q == ODD) && out_ready);
    assign out_valid = (state_q != IDLE);
    assign out_odd   = (state_q == ODD);
    assign y_out     = y_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Next-state, history and output-sample selection
    always_comb begin
        state_d  = state_q;
        x_cur_d  = x_cur_q;
        x_prev_d = x_prev_q;
        y_d      = y_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) state_d = EVEN;
            end
            EVEN: begin
                if (out_xfer) begin
                    state_d = ODD;
                    y_d     = odd_prod;
                end
            end
            ODD: begin
                if (out_xfer) state_d = in_xfer ? EVEN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new sample shifts history and loads its even-phase result
        if (in_xfer) begin
            x_prev_d = x_cur_q;
            x_cur_d  = x_in;
            y_d      = even_sum;
        end
        if (flush_req) begin
            x_prev_d = '0;
            x_cur_d  = '0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_cur_q  <= '0;
            x_prev_q <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            x_cur_q  <= x_cur_d;
            x_prev_q <= x_prev_d;
            y_q      <= y_d;
        end
    end

endmodule

// File: tb/tb_fir_interp2.sv
// Scoreboard bench for fir_interp2: directed scenarios plus randomized traffic.
// Expected samples come from a sample-level reference model pushed at input acceptance.
// A negedge monitor pops and compares every output transfer and checks stall stability.
module tb_fir_interp2;

    localparam int WIDTH = 8;
    localparam int OUT_W = 17;
    localparam int C0 = 1;
    localparam int C1 = 2;
    localparam int C2 = 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] y_out;
    logic             out_odd;
`ifdef FIR_INTERP_FLUSH_EN
    logic             flush;
`endif

    fir_interp2 dut (
        .clk       (clk),
        .rst       (rst),
`ifdef FIR_INTERP_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .out_odd   (out_odd)
    );

    typedef struct {
        int y;
        bit odd;
    } exp_t;

    exp_t exp_q[$];
    int   hist_x;
    int   errors;
    int   checks;
    int   cyc;
    int   first_vld;
    int   last_vld;
    bit   rand_rdy;
    bit   stall_prev;
    int   stall_y;
    bit   stall_odd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: one input sample yields its two polyphase outputs
    task automatic model_push(input logic [WIDTH-1:0] x);
        int xs;
        exp_t e;
        xs = int'($signed(x));
        e.y = C0 * xs + C2 * hist_x;
        e.odd = 1'b0;
        exp_q.push_back(e);
        e.y = C1 * xs;
        e.odd = 1'b1;
        exp_q.push_back(e);
        hist_x = xs;
    endtask

    // Monitor: compare each output transfer, verify held outputs during stalls
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (out_valid) begin
                if (first_vld < 0) first_vld = cyc;
                last_vld = cyc;
            end
            if (stall_prev) begin
                chk("stall_valid_held", int'(out_valid), 1);
                chk("stall_y_held", int'($signed(y_out)), stall_y);
                chk("stall_odd_held", int'(out_odd), int'(stall_odd));
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", int'(in_ready), 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got y=%0d odd=%0d, expected no output",
                             $signed(y_out), out_odd);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("y_out", int'($signed(y_out)), e.y);
                    chk("out_odd", int'(out_odd), int'(e.odd));
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_y    = int'($signed(y_out));
            stall_odd  = out_odd;
        end
    end

    // Random downstream backpressure when enabled
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        hist_x = 0;
    endtask

    // Present one sample and hold it until accepted (bounded wait)
    task automatic send(input logic [WIDTH-1:0] x);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        in_valid = 1'b1;
        x_in = x;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_push(x);
                done = 1'b1;
            end else if (++n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        hist_x = 0;
        rand_rdy = 1'b0;
        stall_prev = 1'b0;
        first_vld = -1;
        last_vld = -1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x_in = '0;
        rst = 1'b1;
`ifdef FIR_INTERP_FLUSH_EN
        flush = 1'b0;
`endif
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_out_odd", int'(out_odd), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Basic pair: 10, 20 -> 10,20,30,40
        out_ready = 1'b1;
        send(8'd10);
        send(8'd20);
        drain();

        // Negative extremes and sign extension
        do_reset();
        out_ready = 1'b1;
        send(8'h80);
        send(8'h80);
        drain();

        // Stall in EVEN for three cycles
        do_reset();
        out_ready = 1'b0;
        send(8'd7);
        repeat (3) begin
            @(negedge clk);
            chk("hold_y_out", int'($signed(y_out)), 7);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_out_valid", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Back-to-back streaming: no bubbles across 8 outputs
        do_reset();
        out_ready = 1'b1;
        first_vld = -1;
        last_vld = -1;
        send(8'd1);
        send(8'd2);
        send(8'd3);
        send(8'd4);
        drain();
        chk("stream_span", last_vld - first_vld + 1, 8);

        // Reset while an even sample is pending
        do_reset();
        out_ready = 1'b0;
        send(8'd9);
        @(negedge clk);
        chk("pre_rst_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        hist_x = 0;
        @(negedge clk);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_y_out", int'(y_out), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'd5);
        drain();

`ifdef FIR_INTERP_FLUSH_EN
        // Flush in IDLE restarts history
        do_reset();
        out_ready = 1'b1;
        send(8'd10);
        drain();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        hist_x = 0;
        send(8'd20);
        drain();
`endif

        // Randomized traffic with random gaps and backpressure
        do_reset();
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap == 3) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            send(WIDTH'($urandom_range(0, 255)));
        end
        drain();
        rand_rdy = 1'b0;
        #2;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
